// File: rtl/mux_xbar_bbm_if.sv
// Configuration and status bundle for the console-pin crossbar.
// The host side drives sources and the cfg_* requests; the crossbar answers with status and per-output drive enables.
interface mux_xbar_bbm_if #(
    parameter int INPUT_COUNT  = 16,
    parameter int OUTPUT_COUNT = 16
);
    localparam int SEL_WIDTH  = (INPUT_COUNT  > 1) ? $clog2(INPUT_COUNT)  : 1;
    localparam int ADDR_WIDTH = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;

    logic [INPUT_COUNT-1:0]  sources;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [ADDR_WIDTH-1:0]   cfg_addr;
    logic [SEL_WIDTH-1:0]    cfg_sel;
    logic                    cfg_en;
    logic                    cfg_commit;
    logic                    cfg_err;
    logic                    busy;
    logic                    commit_done;
    logic [OUTPUT_COUNT-1:0] out_en;

    modport master (
        output sources, cfg_valid, cfg_addr, cfg_sel, cfg_en, cfg_commit,
        input  cfg_ready, cfg_err, busy, commit_done, out_en
    );

    modport slave (
        input  sources, cfg_valid, cfg_addr, cfg_sel, cfg_en, cfg_commit,
        output cfg_ready, cfg_err, busy, commit_done, out_en
    );
endinterface

// File: rtl/mux_xbar_bbm.sv
// Registered console-pin crossbar with shadow configuration and break-before-make commit.
// Re-routed outputs float for BBM_CYCLES before driving their new source.
module mux_xbar_bbm #(
    parameter int INPUT_COUNT  = 16,
    parameter int OUTPUT_COUNT = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int BBM_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_xbar_bbm_if.slave           bus,
    output wire [OUTPUT_COUNT-1:0]  out
);
    localparam int SEL_WIDTH  = (INPUT_COUNT  > 1) ? $clog2(INPUT_COUNT)  : 1;
    localparam int ADDR_WIDTH = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
    localparam int SEL_SPAN   = 1 << SEL_WIDTH;
    localparam int ADDR_SPAN  = 1 << ADDR_WIDTH;
    localparam int CNT_WIDTH  = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;

    // Lookup masks: bit k set when encoding k names a real source / output.
    localparam logic [SEL_SPAN-1:0]  SEL_OK  = SEL_SPAN'({INPUT_COUNT{1'b1}});
    localparam logic [ADDR_SPAN-1:0] ADDR_OK = ADDR_SPAN'({OUTPUT_COUNT{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAKE} state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [SEL_WIDTH-1:0]    r_sh_sel    [OUTPUT_COUNT];
    logic [SEL_WIDTH-1:0]    r_act_sel   [OUTPUT_COUNT];
    logic [SEL_WIDTH-1:0]    w_sh_sel_nx [OUTPUT_COUNT];
    logic [OUTPUT_COUNT-1:0] r_sh_en;
    logic [OUTPUT_COUNT-1:0] r_act_en;
    logic [OUTPUT_COUNT-1:0] w_sh_en_nx;
    logic [OUTPUT_COUNT-1:0] r_force_z;
    logic [OUTPUT_COUNT-1:0] w_changed;
    logic [OUTPUT_COUNT-1:0] w_out_en;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_cfg_err;
    logic                    r_commit_done;
    logic                    w_ready;
    logic                    w_wr;
    logic                    w_start;
    logic                    w_trivial;
    logic                    w_apply;
    logic                    w_busy;
    logic [INPUT_COUNT-1:0]  w_src;
    logic [SEL_SPAN-1:0]     w_src_pad;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_src = bus.sources;
        end else begin : g_sync
            logic [INPUT_COUNT-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
                end else begin
                    r_sync[0] <= bus.sources;
                    for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
                end
            end

            assign w_src = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_src_pad = SEL_SPAN'(w_src);
    assign w_ready   = (r_state == S_IDLE);
    assign w_wr      = bus.cfg_valid && w_ready;

    // Shadow as it stands after this edge's write, so a same-cycle commit sees it.
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
        w_sh_en_nx = r_sh_en;
        w_changed  = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            w_sh_sel_nx[i] = r_sh_sel[i];
            if (w_wr && bus.cfg_addr == ADDR_WIDTH'(i)) begin
                w_sh_sel_nx[i] = bus.cfg_sel;
                w_sh_en_nx[i]  = bus.cfg_en;
            end
            w_changed[i] = (w_sh_en_nx[i] != r_act_en[i]) ||
                           ((w_sh_en_nx[i] || r_act_en[i]) && (w_sh_sel_nx[i] != r_act_sel[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_trivial  = 1'b0;
        w_apply    = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_commit) begin
                    if (|w_changed) begin
                        w_start    = 1'b1;
                        w_state_nx = (BBM_CYCLES == 1) ? S_MAKE : S_BREAK;
                    end else begin
                        w_trivial  = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_WIDTH'(1)) w_state_nx = S_MAKE;
            end
            S_MAKE: begin
                // Last hi-Z cycle; the new routing is loaded at its closing edge.
                w_busy     = 1'b1;
                w_apply    = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: shadow and active tables are small flop arrays that must power up disabled, so they are reset.
            for (int i = 0; i < OUTPUT_COUNT; i++) begin
                r_sh_sel[i]  <= '0;
                r_act_sel[i] <= '0;
            end
            r_sh_en       <= '0;
            r_act_en      <= '0;
            r_force_z     <= '0;
            r_cnt         <= '0;
            r_cfg_err     <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_cfg_err     <= w_wr && !ADDR_OK[bus.cfg_addr];
            r_commit_done <= w_trivial || w_apply;
            r_sh_sel      <= w_sh_sel_nx;
            r_sh_en       <= w_sh_en_nx;
            if (w_start) begin
                r_force_z <= w_changed;
                r_cnt     <= CNT_WIDTH'(BBM_CYCLES - 1);
            end else if (r_state == S_BREAK) begin
                r_cnt     <= r_cnt - CNT_WIDTH'(1);
            end
            if (w_apply) begin
                r_act_sel <= r_sh_sel;
                r_act_en  <= r_sh_en;
                r_force_z <= '0;
            end
        end
    end

    generate
        for (genvar g = 0; g < OUTPUT_COUNT; g++) begin : g_out
            assign w_out_en[g] = r_act_en[g] && SEL_OK[r_act_sel[g]] && !r_force_z[g];
            assign out[g]      = w_out_en[g] ? w_src_pad[r_act_sel[g]] : 1'bz;
        end
    endgenerate

    assign bus.out_en      = w_out_en;
    assign bus.cfg_ready   = w_ready;
    assign bus.busy        = w_busy;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.commit_done = r_commit_done;
endmodule
